bus_interconnect: RTL and testbench

Parametrised single-master, N-slave memory-mapped interconnect between the core's load/store port and the SoC peripherals (memory, LEDs, UART, GPIO and future slaves). It replaces the fixed four-slave combinational bus with a registered, state-machine-driven transaction path. The path adds range-checked address decoding, exactly one transaction in flight, and an error response for unmapped addresses and for slaves that never answer.

---
 rtl/bus_interconnect.sv | 151 +++++++++++++++
 tb/tb_bus_interconnect.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_interconnect.sv
// Single-master, N-slave registered interconnect: address decode, one transaction in flight,
// and error responses. Define BUS_TIMEOUT_EN to add the slave-timeout counter and ACCESS->ERR path.
module bus_interconnect #(
   parameter int unsigned NUM_SLAVES     = 4,
   parameter int unsigned SEL_MSB        = 31,
   parameter int unsigned SEL_LSB        = 28,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [31:0] ERROR_DATA     = 32'hDEAD_BEEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       read,
   input  logic                       write,
   input  logic [31:0]                address,
   input  logic [31:0]                write_data,
   output logic [31:0]                read_data,
   output logic                       response,
   output logic                       error,
   output logic [NUM_SLAVES-1:0]      slave_read,
   output logic [NUM_SLAVES-1:0]      slave_write,
   output logic [31:0]                slave_address,
   output logic [31:0]                slave_write_data,
   input  logic [32*NUM_SLAVES-1:0]   slave_read_data,
   input  logic [NUM_SLAVES-1:0]      slave_response
);

   localparam int unsigned SEL_W = SEL_MSB - SEL_LSB + 1;
   localparam logic [SEL_W:0] SLAVE_COUNT = (SEL_W + 1)'(NUM_SLAVES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2,
      ERR    = 2'd3
   } state_t;

   state_t             state_reg, state_next;
   logic [31:0]        addr_reg;
   logic [31:0]        wdata_reg;
   logic               is_write_reg;
   logic [SEL_W-1:0]   sel_reg;
   logic [31:0]        read_data_reg;

   logic [SEL_W-1:0]   sel_in;
   logic               sel_valid_in;
   logic               accept;
   logic               in_access;
   logic               sel_resp;
   logic [31:0]        sel_rdata;
   logic               timeout_hit;

   assign sel_in       = address[SEL_MSB:SEL_LSB];
   assign sel_valid_in = ({1'b0, sel_in} < SLAVE_COUNT);
   assign accept       = (state_reg == IDLE) && (read || write);
   assign in_access    = (state_reg == ACCESS);

   // Only the addressed slave's response and data are observed.
   always_comb begin
      sel_resp  = 1'b0;
      sel_rdata = '0;
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
         if (sel_reg == SEL_W'(i)) begin
            sel_resp  = slave_response[i];
            sel_rdata = slave_read_data[32*i +: 32];
         end
      end
   end

`ifdef BUS_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (!in_access) begin
         count_reg <= '0;
      end else if (!sel_resp) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign timeout_hit = (count_reg == COUNT_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (read || write) begin
               state_next = sel_valid_in ? ACCESS : ERR;
            end
         end
         ACCESS: begin
            // A response in the final timeout cycle still completes normally.
            if (sel_resp) begin
               state_next = RESP;
            end else if (timeout_hit) begin
               state_next = ERR;
            end
         end
         RESP:    state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         is_write_reg  <= 1'b0;
         sel_reg       <= '0;
         read_data_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            addr_reg     <= address;
            wdata_reg    <= write_data;
            is_write_reg <= write;
            sel_reg      <= sel_in;
         end
         if (state_next == ERR) begin
            read_data_reg <= ERROR_DATA;
         end else if (state_next == RESP) begin
            read_data_reg <= is_write_reg ? 32'h0 : sel_rdata;
         end
      end
   end

   // Strobes decode straight from registered state so a reset drops them immediately.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_strobe
         assign slave_read[gi]  = in_access && !is_write_reg && (sel_reg == SEL_W'(gi));
         assign slave_write[gi] = in_access &&  is_write_reg && (sel_reg == SEL_W'(gi));
      end
   endgenerate

   assign response         = (state_reg == RESP) || (state_reg == ERR);
   assign error            = (state_reg == ERR);
   assign read_data        = read_data_reg;
   assign slave_address    = addr_reg;
   assign slave_write_data = wdata_reg;

endmodule

// File: tb/tb_bus_interconnect.sv
// Self-checking bench for bus_interconnect: directed vector table, a reset-abort sequence,
// and randomized transactions checked against a behavioural transaction model.
module tb_bus_interconnect;

   localparam int NS = 4;
   localparam int TO = 8;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
`ifdef BUS_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               read = 1'b0;
   logic               write = 1'b0;
   logic [31:0]        address = '0;
   logic [31:0]        write_data = '0;
   logic [31:0]        read_data;
   logic               response;
   logic               error;
   logic [NS-1:0]      slave_read;
   logic [NS-1:0]      slave_write;
   logic [31:0]        slave_address;
   logic [31:0]        slave_write_data;
   logic [32*NS-1:0]   slave_read_data;
   logic [NS-1:0]      slave_response = '0;
   logic [31:0]        sdata [NS];

   always #5 clk = ~clk;

   always_comb begin
      slave_read_data = '0;
      for (int i = 0; i < NS; i++) slave_read_data[32*i +: 32] = sdata[i];
   end

   bus_interconnect #(
      .NUM_SLAVES(NS), .SEL_MSB(31), .SEL_LSB(28),
      .TIMEOUT_CYCLES(TO), .ERROR_DATA(ERRD)
   ) dut (
      .clk(clk), .reset(reset), .read(read), .write(write),
      .address(address), .write_data(write_data), .read_data(read_data),
      .response(response), .error(error),
      .slave_read(slave_read), .slave_write(slave_write),
      .slave_address(slave_address), .slave_write_data(slave_write_data),
      .slave_read_data(slave_read_data), .slave_response(slave_response)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Transaction-level model: how many strobe cycles, whether it errors, what data comes back.
   task automatic model(input logic wr, input logic [31:0] addr, input int wait_n,
                        input logic [31:0] sd, output int strobes, output logic err,
                        output logic [31:0] rdata);
      int sel;
      sel = int'(addr[31:28]);
      if (sel >= NS) begin
         strobes = 0; err = 1'b1; rdata = ERRD;
      end else if (TO_EN && wait_n >= TO) begin
         strobes = TO; err = 1'b1; rdata = ERRD;
      end else begin
         strobes = wait_n + 1; err = 1'b0; rdata = wr ? 32'h0 : sd;
      end
   endtask

   task automatic run_txn(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wd, input int wait_n,
                          input logic [NS-1:0] stray, input logic [31:0] sd,
                          input int exp_strobes, input logic exp_err, input logic [31:0] exp_rdata);
      int sel, seen, cyc;
      logic got;
      logic [NS-1:0] hot;
      sel = int'(addr[31:28]);
      hot = (sel < NS) ? (NS'(1) << sel) : '0;
      for (int i = 0; i < NS; i++) sdata[i] = $urandom;
      if (sel < NS) sdata[sel] = sd;
      @(negedge clk);
      read = rd; write = wr; address = addr; write_data = wd; slave_response = '0;
      seen = 0; cyc = 0; got = 1'b0;
      while (!got && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (response) begin
            got = 1'b1;
         end else if (slave_read != '0 || slave_write != '0) begin
            seen++;
            if (seen == 1) begin
               check({tag, "_sread"}, 32'(slave_read), 32'(wr ? '0 : hot));
               check({tag, "_swrite"}, 32'(slave_write), 32'(wr ? hot : '0));
            end
            check({tag, "_saddr"}, slave_address, addr);
            check({tag, "_swdata"}, slave_write_data, wd);
            address = $urandom;
            write_data = $urandom;
            slave_response = stray & ~hot;
            if (seen == wait_n + 1) slave_response = slave_response | hot;
         end
      end
      check({tag, "_done"}, 32'(got), 32'd1);
      check({tag, "_strobe_cycles"}, 32'(seen), 32'(exp_strobes));
      check({tag, "_latency"}, 32'(cyc), 32'(exp_strobes + 1));
      check({tag, "_error"}, 32'(error), 32'(exp_err));
      check({tag, "_rdata"}, read_data, exp_rdata);
      check({tag, "_strobes_off"}, 32'({slave_read, slave_write}), 32'd0);
      read = 1'b0; write = 1'b0; slave_response = '0;
      @(negedge clk);
      check({tag, "_pulse"}, 32'({response, error}), 32'd0);
      $display("txn %s rd=%0d wr=%0d addr=%h strobes=%0d err=%0d rdata=%h",
               tag, rd, wr, addr, seen, error, read_data);
   endtask

   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          wait_n;
      logic [NS-1:0] stray;
      logic [31:0] sd;
      int          exp_strobes;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int strobes;
      logic err;
      logic [31:0] rdata;

      vecs.push_back('{"rd_s1",     1, 0, 32'h1000_0004, 32'h0,         0,   4'b0000, 32'hA5A5_0001, 1, 0, 32'hA5A5_0001});
      vecs.push_back('{"wr_s3",     0, 1, 32'h3000_0010, 32'h0000_00FF, 3,   4'b0000, 32'h1111_2222, 4, 0, 32'h0});
      vecs.push_back('{"rd_unmap",  1, 0, 32'h7000_0000, 32'h0,         0,   4'b0000, 32'h0,         0, 1, ERRD});
      vecs.push_back('{"both_s0",   1, 1, 32'h0000_0020, 32'h0000_1234, 1,   4'b0100, 32'h9999_9999, 2, 0, 32'h0});
      vecs.push_back('{"rd_s2",     1, 0, 32'h2000_0000, 32'h0,         2,   4'b1011, 32'h5555_AAAA, 3, 0, 32'h5555_AAAA});
      vecs.push_back('{"wr_unmap",  0, 1, 32'hF000_0000, 32'h0000_0001, 0,   4'b0000, 32'h0,         0, 1, ERRD});
      vecs.push_back('{"rd_last",   1, 0, 32'h3FFF_FFFC, 32'h0,         0,   4'b0111, 32'h0BAD_F00D, 1, 0, 32'h0BAD_F00D});
`ifdef BUS_TIMEOUT_EN
      vecs.push_back('{"rd_timeout",1, 0, 32'h0000_0000, 32'h0,         100, 4'b0000, 32'h1234_5678, 8, 1, ERRD});
      vecs.push_back('{"rd_lastcyc",1, 0, 32'h0000_0000, 32'h0,         7,   4'b0000, 32'h8765_4321, 8, 0, 32'h8765_4321});
`else
      vecs.push_back('{"rd_longwait",1, 0, 32'h0000_0000, 32'h0,        20,  4'b0000, 32'h8765_4321, 21, 0, 32'h8765_4321});
`endif

      for (int i = 0; i < NS; i++) sdata[i] = '0;
      #1 reset = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_response", 32'(response), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_rdata", read_data, 32'd0);
      check("rst_strobes", 32'({slave_read, slave_write}), 32'd0);
      check("rst_saddr", slave_address, 32'd0);
      check("rst_swdata", slave_write_data, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      foreach (vecs[k]) begin
         run_txn(vecs[k].name, vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].wdata,
                 vecs[k].wait_n, vecs[k].stray, vecs[k].sd,
                 vecs[k].exp_strobes, vecs[k].exp_err, vecs[k].exp_rdata);
      end

      // Reset in the middle of an access aborts it with no response.
      @(negedge clk);
      read = 1'b1; address = 32'h2000_0008;
      @(negedge clk);
      check("abort_strobe", 32'(slave_read), 32'h4);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("abort_strobes_off", 32'({slave_read, slave_write}), 32'd0);
      check("abort_no_resp", 32'(response), 32'd0);
      check("abort_saddr", slave_address, 32'd0);
      read = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      $display("txn abort reset mid-access on slave 2");
      run_txn("after_abort", 1, 0, 32'h0000_0040, 32'h0, 0, 4'b0000, 32'hC0DE_0000, 1, 0, 32'hC0DE_0000);

      for (int r = 0; r < 40; r++) begin
         logic rd, wr;
         logic [31:0] addr, wd, sd;
         int kind, wait_n;
         logic [NS-1:0] stray;
         kind   = $urandom_range(0, 2);
         rd     = (kind != 1);
         wr     = (kind != 0);
         addr   = $urandom;
         addr[31:28] = 4'($urandom_range(0, 5));
         wd     = $urandom;
         sd     = $urandom;
         wait_n = $urandom_range(0, 10);
         stray  = NS'($urandom);
         model(wr, addr, wait_n, sd, strobes, err, rdata);
         run_txn($sformatf("rand%0d", r), rd, wr, addr, wd, wait_n, stray, sd, strobes, err, rdata);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
